// File: rtl/collatz_sched.sv
// Round-robin scheduler sharing one collatz kernel between NUM_REQ requesters.
// Handshake: a requester holds req_valid/req_n until it sees its one-cycle
// req_ready pulse; the job result returns as a one-cycle resp_valid pulse on
// the same requester's bit, with resp_data/resp_timeout valid in that cycle.
// FSM state is visible as r_state (state_t) for checkers.
module collatz_sched #(
  parameter int NUM_REQ    = 4,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_n,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [31:0]            resp_data,
  output logic                   resp_timeout,
  output logic                   busy,
  output logic                   kern_rst_n,
  output logic                   kern_start,
  output logic [31:0]            kern_n,
  input  logic                   kern_finish,
  input  logic [31:0]            kern_ret
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_KRST, S_RUN, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_last_grant;
  logic [GW-1:0]      r_g_q;
  logic [31:0]        r_n_q;
  logic [RW-1:0]      r_rcnt;
  logic [WW-1:0]      r_wdog;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [31:0]        r_resp_data;
  logic               r_resp_timeout;
  logic               r_busy;
  logic               r_kern_rst_n;
  logic               r_kern_start;
  logic [31:0]        r_kern_n;

  logic               w_found;
  logic [GW-1:0]      w_gnt;
  logic [GW-1:0]      w_idx;
  logic [31:0]        w_gnt_n;
  logic               w_wdog_exp;

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_timeout = r_resp_timeout;
  assign busy         = r_busy;
  assign kern_rst_n   = r_kern_rst_n;
  assign kern_start   = r_kern_start;
  assign kern_n       = r_kern_n;

  assign w_wdog_exp = (r_wdog == WW'(TIMEOUT - 1));

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    w_gnt_n = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = GW'((int'(r_last_grant) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
        w_gnt_n = req_n[{w_idx, 5'd0} +: 32];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; kernel finish beats the watchdog on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_KRST;
      S_KRST:  if (r_rcnt == '0) w_state_nxt = S_RUN;
      S_RUN:   if (kern_finish || w_wdog_exp) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant   <= GW'(NUM_REQ - 1);
      r_g_q          <= '0;
      r_n_q          <= '0;
      r_rcnt         <= '0;
      r_wdog         <= '0;
      r_req_ready    <= '0;
      r_resp_valid   <= '0;
      r_resp_data    <= '0;
      r_resp_timeout <= 1'b0;
      r_busy         <= 1'b0;
      r_kern_rst_n   <= 1'b0;
      r_kern_start   <= 1'b0;
      r_kern_n       <= '0;
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE);
      r_kern_rst_n <= (w_state_nxt == S_RUN);
      r_kern_start <= (w_state_nxt == S_RUN);
      r_req_ready  <= '0;
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_req_ready <= ONE << w_gnt;
            r_n_q       <= w_gnt_n;
            r_g_q       <= w_gnt;
            r_rcnt      <= RW'(RST_CYCLES - 1);
          end
        end
        S_KRST: begin
          if (r_rcnt == '0) begin
            r_wdog   <= '0;
            r_kern_n <= r_n_q;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        S_RUN: begin
          r_wdog <= r_wdog + 1'b1;
          if (kern_finish) begin
            r_resp_data    <= kern_ret;
            r_resp_timeout <= 1'b0;
            r_resp_valid   <= ONE << r_g_q;
          end else if (w_wdog_exp) begin
            r_resp_data    <= 32'hFFFF_FFFF;
            r_resp_timeout <= 1'b1;
            r_resp_valid   <= ONE << r_g_q;
          end
        end
        S_RESP: begin
          r_last_grant <= r_g_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_sched.sv
// Bench for collatz_sched: behavioural kernel with programmable run length,
// scoreboard queues for grants and responses, directed stimulus sequence.
module tb_collatz_sched;

  localparam int NUM_REQ    = 4;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 16;
  localparam int W          = 44;  // {run[7:0], timeout, id[2:0], data[31:0]}

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_n;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_timeout;
  logic                  busy;
  logic                  kern_rst_n;
  logic                  kern_start;
  logic [31:0]           kern_n;
  logic                  kern_finish;
  logic [31:0]           kern_ret;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int k_lat    = 3;
  int k_cnt;
  int resp_seen = 0;
  int run_cnt   = 0;
  int ready_cyc = 0;
  bit hold      = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   gnt_q[$];

  collatz_sched #(.NUM_REQ(NUM_REQ), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_n(req_n),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_timeout(resp_timeout), .busy(busy), .kern_rst_n(kern_rst_n),
    .kern_start(kern_start), .kern_n(kern_n), .kern_finish(kern_finish),
    .kern_ret(kern_ret)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned collatz_steps(input int unsigned n);
    int unsigned x = n;
    int unsigned s = 0;
    while (x > 1) begin
      x = x[0] ? 3 * x + 1 : x / 2;
      s++;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] pack(input int run, input bit to, input int id,
                                        input logic [31:0] data);
    return {8'(run), to, 3'(id), data};
  endfunction

  // Kernel model: sync active-low reset, sticky finish k_lat cycles after start.
  always @(posedge clk) begin
    if (!kern_rst_n) begin
      k_cnt       <= 0;
      kern_finish <= 1'b0;
      kern_ret    <= '0;
    end else if (kern_start && !kern_finish) begin
      k_cnt <= k_cnt + 1;
      if (k_cnt + 1 >= k_lat) begin
        kern_finish <= 1'b1;
        kern_ret    <= collatz_steps(kern_n);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [2:0]   g;
    if (rst) begin
      run_cnt = 0;
    end else begin
      if (kern_start) run_cnt++;
      if (req_ready != '0) begin
        check("ready_onehot", 64'($countones(req_ready)), 64'd1);
        if (gnt_q.size() == 0) begin
          check("unexpected_grant", 64'(req_ready), 64'd0);
        end else begin
          g = gnt_q.pop_front();
          check("grant_id", 64'(req_ready), 64'(4'b0001 << g));
        end
        ready_cyc = cyc;
        run_cnt   = 0;
      end
      if (resp_valid != '0) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_id", 64'(resp_valid), 64'(4'b0001 << e[34:32]));
          check("resp_data", 64'(resp_data), 64'(e[31:0]));
          check("resp_timeout", 64'(resp_timeout), 64'(e[35]));
          check("run_cycles", 64'(run_cnt), 64'(e[43:36]));
          check("latency", 64'(cyc - ready_cyc), 64'(RST_CYCLES + int'(e[43:36])));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (!hold) req_valid &= ~req_ready;
  endtask

  task automatic drive(input int id, input logic [31:0] n);
    req_n[32*id +: 32] = n;
    req_valid[id]      = 1'b1;
  endtask

  task automatic wait_resp(input int k);
    int base = resp_seen;
    int budget = 0;
    while (resp_seen < base + k && budget < 2000) begin
      tick();
      budget++;
    end
    check("resp_count", 64'(resp_seen - base), 64'(k));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_kern_rst_n"}, 64'(kern_rst_n), 64'd0);
    check({tag, "_kern_start"}, 64'(kern_start), 64'd0);
    check({tag, "_kern_n"}, 64'(kern_n), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    check({tag, "_resp_timeout"}, 64'(resp_timeout), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int budget;
    rst = 1'b1; req_valid = '0; req_n = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b0;

    // Single job, requester 0, n=6 -> 8
    gnt_q.push_back(3'd0); exp_q.push_back(pack(4, 0, 0, 32'd8));
    drive(0, 32'd6);
    wait_resp(1);
    check("busy_after_job", 64'(busy), 64'd0);

    // Requester 2, n=1 and n=0 -> 0
    gnt_q.push_back(3'd2); exp_q.push_back(pack(4, 0, 2, 32'd0));
    drive(2, 32'd1);
    wait_resp(1);
    gnt_q.push_back(3'd2); exp_q.push_back(pack(4, 0, 2, 32'd0));
    drive(2, 32'd0);
    wait_resp(1);

    // From reset, requesters 0 and 1 together -> order 0 then 1
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    gnt_q.push_back(3'd0); exp_q.push_back(pack(4, 0, 0, 32'd111));
    gnt_q.push_back(3'd1); exp_q.push_back(pack(4, 0, 1, 32'd16));
    drive(0, 32'd27); drive(1, 32'd7);
    wait_resp(2);

    // All four held valid: grants rotate 2,3,0,1
    hold = 1'b1;
    drive(0, 32'd6); drive(1, 32'd7); drive(2, 32'd27); drive(3, 32'd1);
    gnt_q.push_back(3'd2); exp_q.push_back(pack(4, 0, 2, 32'd111));
    gnt_q.push_back(3'd3); exp_q.push_back(pack(4, 0, 3, 32'd0));
    gnt_q.push_back(3'd0); exp_q.push_back(pack(4, 0, 0, 32'd8));
    gnt_q.push_back(3'd1); exp_q.push_back(pack(4, 0, 1, 32'd16));
    wait_resp(4);
    req_valid = '0;
    hold = 1'b0;

    // Watchdog abort: n=27 runs 111 kernel cycles against TIMEOUT=16
    k_lat = int'(collatz_steps(27));
    gnt_q.push_back(3'd0); exp_q.push_back(pack(TIMEOUT, 1, 0, 32'hFFFF_FFFF));
    drive(0, 32'd27);
    wait_resp(1);
    repeat (3) tick();
    check("timeout_hold_data", 64'(resp_data), 64'hFFFF_FFFF);
    check("timeout_hold_flag", 64'(resp_timeout), 64'd1);

    // Kernel re-reset between jobs: n=6 -> 8
    k_lat = 3;
    gnt_q.push_back(3'd0); exp_q.push_back(pack(4, 0, 0, 32'd8));
    drive(0, 32'd6);
    wait_resp(1);

    // Finish on the watchdog's last cycle wins
    k_lat = TIMEOUT - 1;
    gnt_q.push_back(3'd0); exp_q.push_back(pack(TIMEOUT, 0, 0, 32'd16));
    drive(0, 32'd7);
    wait_resp(1);

    // Reset mid-RUN: job dropped, outputs clear immediately
    k_lat = 200;
    gnt_q.push_back(3'd1);
    drive(1, 32'd27);
    budget = 0;
    while (!kern_start && budget < 50) begin
      tick();
      budget++;
    end
    check("reached_run", 64'(kern_start), 64'd1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    repeat (2) tick();
    rst = 1'b0;
    k_lat = 3;

    // After reset requester 0 first, then 2
    gnt_q.push_back(3'd0); exp_q.push_back(pack(4, 0, 0, 32'd8));
    gnt_q.push_back(3'd2); exp_q.push_back(pack(4, 0, 2, 32'd16));
    drive(2, 32'd7); drive(0, 32'd6);
    wait_resp(2);
    repeat (4) tick();
    check("hold_data", 64'(resp_data), 64'd16);
    check("hold_timeout", 64'(resp_timeout), 64'd0);
    check("busy_final", 64'(busy), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("gnt_q_drained", 64'(gnt_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
